mmio_gpio: RTL and testbench

//  Parametrised memory-mapped switch/LED peripheral for the SOPC; replaces the raw switch_on/led_out wiring.

---
 rtl/mmio_gpio_pkg.sv | 19 +
 rtl/mmio_gpio_if.sv | 17 +
 rtl/mmio_gpio_debounce.sv | 59 +++++
 rtl/mmio_gpio.sv | 106 ++++++++++
 tb/tb_mmio_gpio.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/mmio_gpio_pkg.sv
// Purpose: shared register offsets, bus width and default window base for the GPIO peripheral.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mmio_gpio_pkg;

  localparam int          REG_BUS_W         = 32;
  localparam logic [31:0] GPIO_DEFAULT_BASE = 32'h0000_1000;

  // Word offset inside the 16-byte window, taken from addr[3:2].
  typedef enum logic [1:0] {
    GPIO_OFF_SW   = 2'd0,
    GPIO_OFF_LED  = 2'd1,
    GPIO_OFF_EDGE = 2'd2,
    GPIO_OFF_MASK = 2'd3
  } gpio_off_e;

  typedef logic [REG_BUS_W-1:0] reg_bus_t;

endpackage

// File: rtl/mmio_gpio_if.sv
// Purpose: core data-port bus (ce/we/addr/data) shared by data_ram and memory-mapped peripherals.
// Latency: reads are combinational; writes take effect at the next rising edge.
// Backpressure: none; every access completes in the cycle it is presented.
interface mmio_gpio_if;
  import mmio_gpio_pkg::*;

  logic        ce;
  logic        we;
  logic [31:0] addr;
  reg_bus_t    data_i;
  reg_bus_t    data_o;
  logic        hit_o;

  modport master (output ce, we, addr, data_i, input data_o, hit_o);
  modport slave  (input ce, we, addr, data_i, output data_o, hit_o);

endinterface

// File: rtl/mmio_gpio_debounce.sv
// Purpose: one switch channel: 2-FF synchroniser, hold counter, accepted (stable) level and change pulse.
// Latency: raw change reaches stable_o after 2 + DEBOUNCE_CYC cycles; edge_o is high in the cycle before.
// Backpressure: none; free-running per channel.
module mmio_gpio_debounce #(
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o,
  output logic edge_o
);

  localparam int                CNT_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             edge_pulse;

  // Next-state: synced level must differ from stable for DEBOUNCE_CYC cycles in a row to be accepted.
  always_comb begin
    sync1_d    = raw_i;
    sync2_d    = sync1_q;
    stable_d   = stable_q;
    cnt_d      = '0;
    edge_pulse = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d   = sync2_q;
        edge_pulse = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset throws away any count in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  // Pulse coincides with the stable update so status and SW_DATA change on the same edge.
  assign edge_o   = edge_pulse;

endmodule

// File: rtl/mmio_gpio.sv
// Purpose: memory-mapped switch/LED peripheral: SW_DATA, LED_DATA, W1C EDGE_STS, IRQ_MASK and a maskable irq.
// Latency: zero-cycle reads, writes visible next cycle, irq_o one cycle after EDGE_STS.
// Backpressure: none; accesses are never stalled.
module mmio_gpio
  import mmio_gpio_pkg::*;
#(
  parameter int          SW_WIDTH     = 12,
  parameter int          LED_WIDTH    = 32,
  parameter int          DEBOUNCE_CYC = 1000,
  parameter logic [31:0] BASE_ADDR    = GPIO_DEFAULT_BASE
) (
  input  logic                 clk,
  input  logic                 rst,
  mmio_gpio_if.slave           bus,
  input  logic [SW_WIDTH-1:0]  switch_on,
  output logic [LED_WIDTH-1:0] led_out,
  output logic                 irq_o
);

  logic [SW_WIDTH-1:0]  sw_stable;
  logic [SW_WIDTH-1:0]  sw_edge;

  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [SW_WIDTH-1:0]  sts_q, sts_d;
  logic [SW_WIDTH-1:0]  mask_q, mask_d;
  logic                 irq_q, irq_d;

  logic                 hit;
  logic                 wr;
  gpio_off_e            off;
  reg_bus_t             rd_val;
  logic [SW_WIDTH-1:0]  w1c_bits;
  logic                 unused_bus_bits;

  genvar g;
  generate
    for (g = 0; g < SW_WIDTH; g++) begin : g_ch
      mmio_gpio_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
        .clk      (clk),
        .rst      (rst),
        .raw_i    (switch_on[g]),
        .stable_o (sw_stable[g]),
        .edge_o   (sw_edge[g])
      );
    end
  endgenerate

  // Address decode: 16-byte window, low two address bits ignored.
  always_comb begin
    hit = bus.ce & (bus.addr[31:4] == BASE_ADDR[31:4]);
    wr  = hit & bus.we;
    off = gpio_off_e'(bus.addr[3:2]);
  end

  // Register next-state; a new edge pulse outranks a W1C of the same bit.
  always_comb begin
    led_d    = led_q;
    mask_d   = mask_q;
    w1c_bits = '0;
    if (wr) begin
      unique case (off)
        GPIO_OFF_LED:  led_d    = bus.data_i[LED_WIDTH-1:0];
        GPIO_OFF_EDGE: w1c_bits = bus.data_i[SW_WIDTH-1:0];
        GPIO_OFF_MASK: mask_d   = bus.data_i[SW_WIDTH-1:0];
        default:       ;
      endcase
    end
    sts_d = (sts_q & ~w1c_bits) | sw_edge;
    irq_d = |(sts_q & mask_q);
  end

  // Registers and interrupt flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q  <= '0;
      sts_q  <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      led_q  <= led_d;
      sts_q  <= sts_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  // Read mux; bus sees zero unless this is a read hitting the window.
  always_comb begin
    rd_val = '0;
    unique case (off)
      GPIO_OFF_SW:   rd_val[SW_WIDTH-1:0]  = sw_stable;
      GPIO_OFF_LED:  rd_val[LED_WIDTH-1:0] = led_q;
      GPIO_OFF_EDGE: rd_val[SW_WIDTH-1:0]  = sts_q;
      GPIO_OFF_MASK: rd_val[SW_WIDTH-1:0]  = mask_q;
      default:       ;
    endcase
    bus.data_o = (hit & ~bus.we) ? rd_val : '0;
  end

  assign bus.hit_o = hit;
  assign led_out   = led_q;
  assign irq_o     = irq_q;

  assign unused_bus_bits = ^{bus.data_i, bus.addr[1:0]};

endmodule

// File: tb/tb_mmio_gpio.sv
// Purpose: directed self-checking bench for mmio_gpio (DEBOUNCE_CYC=8, BASE_ADDR=0x1000).
// Latency: checks exact cycle counts for writes, debounce acceptance and irq.
// Backpressure: n/a.
module tb_mmio_gpio;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] switch_on = '0;
  logic [31:0] led_out;
  logic        irq_o;
  logic [31:0] rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mmio_gpio_if bus_if();

  mmio_gpio #(
    .SW_WIDTH     (12),
    .LED_WIDTH    (32),
    .DEBOUNCE_CYC (8),
    .BASE_ADDR    (32'h0000_1000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .switch_on (switch_on),
    .led_out   (led_out),
    .irq_o     (irq_o)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus_if.ce = 1'b1; bus_if.we = 1'b1; bus_if.addr = a; bus_if.data_i = d;
    tick(1);
    bus_if.ce = 1'b0; bus_if.we = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    bus_if.ce = 1'b1; bus_if.we = 1'b0; bus_if.addr = a;
    #1;
    d = bus_if.data_o;
    bus_if.ce = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++; if (led_out !== 32'h0) begin errors++; $display("FAIL reset_led got=%h exp=%h", led_out, 32'h0); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
    rst = 1'b0;
    bus_rd(32'h1000, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_sw got=%h exp=0", rd); end
    bus_rd(32'h1008, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_edge got=%h exp=0", rd); end
    bus_rd(32'h100C, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mask got=%h exp=0", rd); end
    tick(1);
  endtask

  task automatic test_led_write();
    bus_wr(32'h1004, 32'hA5A5_00FF);
    checks++; if (led_out !== 32'hA5A5_00FF) begin errors++; $display("FAIL led_out got=%h exp=a5a500ff", led_out); end
    bus_rd(32'h1004, rd);
    checks++; if (rd !== 32'hA5A5_00FF) begin errors++; $display("FAIL led_readback got=%h exp=a5a500ff", rd); end
    bus_rd(32'h1006, rd);
    checks++; if (rd !== 32'hA5A5_00FF) begin errors++; $display("FAIL led_unaligned got=%h exp=a5a500ff", rd); end
    bus_wr(32'h1000, 32'hFFFF_FFFF);
    bus_rd(32'h1000, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sw_write_ignored got=%h exp=0", rd); end
  endtask

  task automatic test_debounce();
    switch_on[3] = 1'b1;
    tick(9);
    bus_rd(32'h1000, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL debounce_early got=%h exp=0", rd); end
    tick(1);
    bus_rd(32'h1000, rd);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL debounce_accept got=%h exp=8", rd); end
    bus_rd(32'h1008, rd);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL debounce_edge got=%h exp=8", rd); end
    switch_on[4] = 1'b1;
    tick(5);
    switch_on[4] = 1'b0;
    tick(12);
    bus_rd(32'h1000, rd);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL glitch_sw got=%h exp=8", rd); end
    bus_rd(32'h1008, rd);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL glitch_edge got=%h exp=8", rd); end
  endtask

  task automatic test_irq();
    bus_wr(32'h1008, 32'h8);
    bus_rd(32'h1008, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL w1c_clear got=%h exp=0", rd); end
    bus_wr(32'h100C, 32'hFFFF_FFFF);
    bus_rd(32'h100C, rd);
    checks++; if (rd !== 32'hFFF) begin errors++; $display("FAIL mask_width got=%h exp=fff", rd); end
    bus_wr(32'h100C, 32'h8);
    bus_rd(32'h100C, rd);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL mask_write got=%h exp=8", rd); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_idle got=%b exp=0", irq_o); end
    switch_on[3] = 1'b0;
    tick(10);
    bus_rd(32'h1008, rd);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL fall_edge got=%h exp=8", rd); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_lag got=%b exp=0", irq_o); end
    tick(1);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_assert got=%b exp=1", irq_o); end
    bus_wr(32'h1008, 32'h8);
    bus_rd(32'h1008, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL irq_w1c got=%h exp=0", rd); end
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_hold got=%b exp=1", irq_o); end
    tick(1);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_deassert got=%b exp=0", irq_o); end
  endtask

  task automatic test_collision();
    switch_on[3] = 1'b1;
    tick(9);
    bus_wr(32'h1008, 32'h8);
    bus_rd(32'h1008, rd);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL collision_set_wins got=%h exp=8", rd); end
    bus_rd(32'h1000, rd);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL collision_sw got=%h exp=8", rd); end
    bus_wr(32'h1008, 32'h8);
    bus_rd(32'h1008, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL collision_clear got=%h exp=0", rd); end
    tick(1);
  endtask

  task automatic test_decode();
    bus_if.ce = 1'b1; bus_if.we = 1'b1; bus_if.addr = 32'h2004; bus_if.data_i = 32'h1234_5678;
    #1;
    checks++; if (bus_if.hit_o !== 1'b0) begin errors++; $display("FAIL decode_hit got=%b exp=0", bus_if.hit_o); end
    checks++; if (bus_if.data_o !== 32'h0) begin errors++; $display("FAIL decode_data got=%h exp=0", bus_if.data_o); end
    tick(1);
    bus_if.ce = 1'b0; bus_if.we = 1'b0;
    checks++; if (led_out !== 32'hA5A5_00FF) begin errors++; $display("FAIL decode_led got=%h exp=a5a500ff", led_out); end
    bus_if.ce = 1'b1; bus_if.we = 1'b0; bus_if.addr = 32'h100C;
    #1;
    checks++; if (bus_if.hit_o !== 1'b1) begin errors++; $display("FAIL decode_in_window got=%b exp=1", bus_if.hit_o); end
    bus_if.we = 1'b1; bus_if.addr = 32'h1004; bus_if.ce = 1'b0;
    #1;
    checks++; if (bus_if.data_o !== 32'h0) begin errors++; $display("FAIL decode_ce0 got=%h exp=0", bus_if.data_o); end
    bus_if.we = 1'b0;
    tick(1);
  endtask

  task automatic test_reset_mid_count();
    switch_on[6] = 1'b1;
    tick(7);
    bus_rd(32'h1000, rd);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL midcount_pre got=%h exp=8", rd); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if (led_out !== 32'h0) begin errors++; $display("FAIL midcount_led got=%h exp=0", led_out); end
    tick(9);
    bus_rd(32'h1000, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midcount_early got=%h exp=0", rd); end
    tick(1);
    bus_rd(32'h1000, rd);
    checks++; if (rd !== 32'h48) begin errors++; $display("FAIL midcount_accept got=%h exp=48", rd); end
    bus_rd(32'h1008, rd);
    checks++; if (rd !== 32'h48) begin errors++; $display("FAIL midcount_edge got=%h exp=48", rd); end
  endtask

  initial begin
    bus_if.ce = 1'b0;
    bus_if.we = 1'b0;
    bus_if.addr = 32'h0;
    bus_if.data_i = 32'h0;
    test_reset();
    test_led_write();
    test_debounce();
    test_irq();
    test_collision();
    test_decode();
    test_reset_mid_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
